decode_stage: RTL and testbench
===============================

# decode_stage

Second stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. Holds the IF/ID pipeline register, decodes the instruction, generates immediates, reads the integrated 32×32 register file, and drives the registered ID/EX bundle to execute. Detects load-use hazards and returns a `hazard` stall request to fetch. Supports a flush from execute on taken branches and jumps.

## Interface
- `NOP_INSTR`, default 32'h0000_0013: bubble instruction, `addi x0,x0,0`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous active-low reset.
- `pc_in`  in  32  fetch `address`; the PC of `instr_in`.
- `instr_in`  in  32  instruction word for `pc_in`, valid in the same cycle.
- `flush`  in  1  taken branch/jump in execute; kill IF/ID and ID/EX.
- `wb_we`, `wb_rd[4:0]`, `wb_data[31:0]`  in  writeback port to the register file.
- `hazard`  out  1  to fetch; holds the PC when high.
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  32 each.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  register indices, for forwarding.
- `ex_alu_op`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `ex_alu_src`  out  1  1 selects `ex_imm` as ALU operand B.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg`, `ex_branch`, `ex_jump`, `ex_illegal`  out  1 each.

## Operation
- IF/ID register holds `id_pc`, `id_instr` and `id_valid`.
  - Loads `pc_in`/`instr_in` with `id_valid=1` each cycle, unless a stall or flush occurs.
- Decode covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE.
  - FENCE decodes as a NOP.
  - Any other opcode sets `ex_illegal=1` and forces every write/mem/branch control bit to 0.
- Immediates are sign-extended per type: I, S, B (bit 0 = 0), U (low 12 bits = 0), J (bit 0 = 0).
  - SLLI/SRLI/SRAI use `imm[4:0]`; `instr[30]` selects SRA.
  - LUI → PASSB. AUIPC → ADD, with execute selecting PC as operand A.
- `ex_rd` is forced to 0 for any instruction with `ex_reg_write=0`.
- Register file: x0 always reads 0; writes to x0 are ignored. It is written at the clock edge when `wb_we=1`.
- `hazard` is combinational, from registered state only (no path from `instr_in`). It is 1 when all of the following hold:
  - `ex_valid` and `ex_mem_read` are 1;
  - `ex_rd != 0`;
  - `ex_rd` equals `id_rs1` or `id_rs2`, and the IF/ID instruction actually uses that source;
  - `flush=0`.
- Stall (`hazard=1`): IF/ID holds its contents, and ID/EX loads a bubble (all control 0, `ex_valid=0`).
- Flush (priority over stall and normal load): IF/ID loads `NOP_INSTR` with `id_valid=0`; ID/EX loads a bubble.

## Timing
- Reset values:
  - IF/ID: `id_instr=NOP_INSTR`, `id_pc=0`, `id_valid=0`.
  - ID/EX: every `ex_*` output is 0.
  - `hazard=0`.
  - Register file is NOT cleared.
- Latency: an instruction at `pc_in` in cycle N is in IF/ID in N+1 and appears on `ex_*` in N+2.
- A load-use stall lasts exactly one cycle. The next cycle `ex_mem_read=0` (bubble), so `hazard` drops.
- `flush` together with `hazard`: flush wins and `hazard` is 0 that cycle.
- Reset asserted mid-stall or mid-flush: the reset values apply on the next edge.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A read of `rs` with `wb_we=1`, `wb_rd==rs` and `rs!=0` returns `wb_data` in the same cycle (write-first).
- Undefined:
  - The read returns the old array value.
  - The pipeline then needs one extra hazard cycle, or execute-stage forwarding, for writeback-to-decode dependences.

## Test plan
- Reset, then stream `addi x1,x0,5` (0x00500093) at PC 0: two cycles later `ex_valid=1`, `ex_alu_op=0`, `ex_imm=5`, `ex_rd=1`, `ex_reg_write=1`, `ex_pc=0`.
- `lw x2,0(x1)` then `add x3,x2,x1`:
  - one cycle with `hazard=1` and a bubble (`ex_valid=0`);
  - then the add issues with `ex_rs1=2`;
  - exactly one stall cycle.
- `lw x0,0(x1)` then `add x3,x0,x1`: `hazard` stays 0.
- `flush` asserted while `hazard=1`: the next cycle has `ex_valid=0` and `id_valid=0`; `hazard=0` during the flush cycle.
- `wb_we=1`, `wb_rd=5`, `wb_data=0xDEADBEEF` while decoding `add x6,x5,x0`:
  - with the macro, `ex_rs1_data=0xDEADBEEF`;
  - without it, the old x5 value.
- Opcode 7'b1111111: `ex_illegal=1`, `ex_reg_write=0`, `ex_mem_write=0`, `ex_rd=0`.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode: IF/ID register, decoder, 32x32 regfile, registered ID/EX bundle; pc_in reaches ex_* two cycles later.
// A load-use dependence raises hazard: fetch holds, IF/ID holds, ID/EX bubbles. Optional macro DECODE_WB_BYPASS_EN: write-first regfile reads.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        hazard,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        illegal;
  } idex_t;

  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  idex_t       ex_q, ex_d, dec;
  logic [31:0] regs_q [32];

  logic        use_rs1, use_rs2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = id_instr_q[6:0];
  assign funct3 = id_instr_q[14:12];
  assign rs1_f  = id_instr_q[19:15];
  assign rs2_f  = id_instr_q[24:20];
  assign rd_f   = id_instr_q[11:7];

  assign imm_i = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
  assign imm_s = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
  assign imm_b = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7], id_instr_q[30:25], id_instr_q[11:8], 1'b0};
  assign imm_u = {id_instr_q[31:12], 12'h000};
  assign imm_j = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12], id_instr_q[20], id_instr_q[30:21], 1'b0};

  // instr[30] is an immediate bit for ADDI, so it only selects SUB on register-register ops.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_op);
    case (f3)
      3'b000:  alu_sel = (alt && is_op) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
`ifdef DECODE_WB_BYPASS_EN
    if (idx == 5'd0)                    rf_read = 32'h0;
    else if (wb_we && (wb_rd == idx))   rf_read = wb_data;
    else                                rf_read = regs_q[idx];
`else
    rf_read = (idx == 5'd0) ? 32'h0 : regs_q[idx];
`endif
  endfunction

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI:    begin dec.imm = imm_u; dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      OPC_AUIPC:  begin dec.imm = imm_u; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      OPC_JAL:    begin dec.imm = imm_j; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1; end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
        dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm       = (funct3[1:0] == 2'b01) ? {27'h0, id_instr_q[24:20]} : imm_i;
        dec.alu_op    = alu_sel(funct3, id_instr_q[30], 1'b0);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        use_rs1       = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op    = alu_sel(funct3, id_instr_q[30], 1'b1);
        dec.reg_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_FENCE:  ;
      default:    dec.illegal = 1'b1;
    endcase
    dec.valid    = id_valid_q;
    dec.pc       = id_pc_q;
    dec.rd       = dec.reg_write ? rd_f : 5'd0;
    dec.rs1      = use_rs1 ? rs1_f : 5'd0;
    dec.rs2      = use_rs2 ? rs2_f : 5'd0;
    dec.rs1_data = rf_read(dec.rs1);
    dec.rs2_data = rf_read(dec.rs2);
  end

  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                  ((use_rs1 && (ex_q.rd == rs1_f)) || (use_rs2 && (ex_q.rd == rs2_f))) &&
                  !flush;

  always_comb begin
    id_pc_d    = pc_in;
    id_instr_d = instr_in;
    id_valid_d = 1'b1;
    if (flush) begin
      id_pc_d    = 32'h0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (hazard) begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
    end
    ex_d = (flush || hazard || !id_valid_q) ? '0 : dec;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      ex_q       <= ex_d;
    end
  end

  // Architectural state survives reset; software initialises it.
  always_ff @(posedge clk) begin
    if (wb_we && (wb_rd != 5'd0)) regs_q[wb_rd] <= wb_data;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, directed stall/flush/reset/bypass sequences, random program vs reference model.
module tb_decode_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset_n, flush, wb_we, hazard, ex_valid;
  logic [31:0] pc_in, instr_in, wb_data, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  wb_rd, ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic        ex_branch, ex_jump, ex_illegal;

  decode_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .instr_in(instr_in), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .hazard(hazard),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [3:0]  alu_op;
    logic [7:0]  ctl;
  } exb_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [7:0]  ctl;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  vec_t        tab [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_bundle(input string nm, input exb_t act, input exb_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic exb_t dut_bundle();
    exb_t r;
    r.valid = ex_valid; r.pc = ex_pc; r.rs1 = ex_rs1; r.rs2 = ex_rs2; r.rd = ex_rd;
    r.rs1_data = ex_rs1_data; r.rs2_data = ex_rs2_data; r.imm = ex_imm; r.alu_op = ex_alu_op;
    r.ctl = {ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump, ex_illegal};
    return r;
  endfunction

  // Reference decode straight from the ISA rules; unused source indices read as x0.
  function automatic exb_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exb_t       r;
    bit         u1, u2;
    logic [3:0] f3_alu [8];
    logic [31:0] ii, is, ib, iu, ij;
    f3_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h000};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    r = '0; r.valid = 1'b1; r.pc = pc; u1 = 0; u2 = 0;
    case (ins[6:0])
      7'h37: begin r.imm = iu; r.alu_op = 4'd10; r.ctl = 8'h90; end
      7'h17: begin r.imm = iu; r.ctl = 8'h90; end
      7'h6F: begin r.imm = ij; r.ctl = 8'h92; end
      7'h67: begin r.imm = ii; r.ctl = 8'h92; u1 = 1; end
      7'h63: begin r.imm = ib; r.alu_op = 4'd1; r.ctl = 8'h04; u1 = 1; u2 = 1; end
      7'h03: begin r.imm = ii; r.ctl = 8'hD8; u1 = 1; end
      7'h23: begin r.imm = is; r.ctl = 8'hA0; u1 = 1; u2 = 1; end
      7'h13: begin
        r.alu_op = f3_alu[ins[14:12]];
        if (ins[14:12] == 3'd5 && ins[30]) r.alu_op = 4'd7;
        r.imm = (ins[13:12] == 2'b01) ? {27'd0, ins[24:20]} : ii;
        r.ctl = 8'h90; u1 = 1;
      end
      7'h33: begin
        r.alu_op = f3_alu[ins[14:12]];
        if (ins[30] && ins[14:12] == 3'd0) r.alu_op = 4'd1;
        if (ins[30] && ins[14:12] == 3'd5) r.alu_op = 4'd7;
        r.ctl = 8'h10; u1 = 1; u2 = 1;
      end
      7'h0F: ;
      default: r.ctl = 8'h01;
    endcase
    r.rd       = r.ctl[4] ? ins[11:7] : 5'd0;
    r.rs1      = u1 ? ins[19:15] : 5'd0;
    r.rs2      = u2 ? ins[24:20] : 5'd0;
    r.rs1_data = m_regs[r.rs1];
    r.rs2_data = m_regs[r.rs2];
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [14];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h03, 7'h23,
            7'h13, 7'h33, 7'h33, 7'h0F, 7'h7F};
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 13)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; pc_in = 32'h0; instr_in = NOP; flush = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // The bench plays fetch: it re-presents the same PC while hazard is high.
  task automatic run_random(input int n, input logic [31:0] base);
    logic [31:0] prog [$];
    exb_t        expq [$];
    bit          bub [$];
    exb_t        prev, cur;
    int          nxt;
    bit          hz, hz_prev, exp_hz;
    prev = '0;
    for (int i = 0; i < n; i++) begin
      prog.push_back(rand_instr());
      cur = ref_dec(prog[i], base + 32'(4 * i));
      if (i > 0 && prev.ctl[6] && prev.rd != 0 && (cur.rs1 == prev.rd || cur.rs2 == prev.rd)) begin
        expq.push_back('0);
        bub.push_back(1'b1);
      end
      expq.push_back(cur);
      bub.push_back(1'b0);
      prev = cur;
    end
    do_reset();
    nxt = 0; hz_prev = 0;
    pc_in = base; instr_in = prog[0];
    for (int e = 1; e <= expq.size() + 1; e++) begin
      tick();
      if (!hz_prev) nxt++;
      hz     = hazard;
      exp_hz = (e - 1 < expq.size()) ? bub[e - 1] : 1'b0;
      check("rnd_hazard", 32'(hz), 32'(exp_hz));
      if (e >= 2) check_bundle("rnd_ex", dut_bundle(), expq[e - 2]);
      pc_in    = base + 32'(4 * nxt);
      instr_in = (nxt < n) ? prog[nxt] : NOP;
      hz_prev  = hz;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exb_t zero_b;
    zero_b = '0;
    reset_n = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    pc_in = 32'h0; instr_in = NOP;

    tab[0]  = '{32'h00500093, 32'h00000005, 5'd1, 4'd0,  8'h90};
    tab[1]  = '{32'h123452B7, 32'h12345000, 5'd5, 4'd10, 8'h90};
    tab[2]  = '{32'h00001397, 32'h00001000, 5'd7, 4'd0,  8'h90};
    tab[3]  = '{32'h0020A423, 32'h00000008, 5'd0, 4'd0,  8'hA0};
    tab[4]  = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd0, 4'd1,  8'h04};
    tab[5]  = '{32'h008000EF, 32'h00000008, 5'd1, 4'd0,  8'h92};
    tab[6]  = '{32'h4031D213, 32'h00000003, 5'd4, 4'd7,  8'h90};
    tab[7]  = '{32'h401101B3, 32'h00000000, 5'd3, 4'd1,  8'h10};
    tab[8]  = '{32'hFFFFFFFF, 32'h00000000, 5'd0, 4'd0,  8'h01};
    tab[9]  = '{32'h0FF0000F, 32'h00000000, 5'd0, 4'd0,  8'h00};
    tab[10] = '{32'hFFF42493, 32'hFFFFFFFF, 5'd9, 4'd3,  8'h90};
    tab[11] = '{32'h0000A103, 32'h00000000, 5'd2, 4'd0,  8'hD8};

    tick(); tick();
    check_bundle("reset_ex", dut_bundle(), zero_b);
    check("reset_hazard", 32'(hazard), 32'h0);
    check("reset_id_valid", 32'(dut.id_valid_q), 32'h0);
    check("reset_id_instr", dut.id_instr_q, NOP);
    reset_n = 1'b1;

    m_regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      m_regs[i] = 32'h1000_0000 + 32'(i * 32'h0101);
      wb_we = 1'b1; wb_rd = 5'(i); wb_data = m_regs[i];
      tick();
    end
    wb_we = 1'b0;

    // Decode table, streamed back to back from PC 0.
    pc_in = 32'h0; instr_in = tab[0].ins;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e >= 2)
        check($sformatf("tab%0d", e - 2),
              {ex_valid, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
               ex_mem_to_reg, ex_branch, ex_jump, ex_illegal, ex_pc[13:0]} ^ ex_imm,
              {1'b1, tab[e - 2].rd, tab[e - 2].alu, tab[e - 2].ctl, 14'(4 * (e - 2))} ^ tab[e - 2].imm);
      pc_in    = 32'(4 * e);
      instr_in = (e < 12) ? tab[e].ins : NOP;
    end

    // Load-use: exactly one stall cycle, then the add issues.
    pc_in = 32'h200; instr_in = 32'h0000A103; tick();
    pc_in = 32'h204; instr_in = 32'h001101B3; tick();
    check("lu_hazard", 32'(hazard), 32'h1);
    check("lu_load_in_ex", {31'h0, ex_mem_read}, 32'h1);
    tick();
    check("lu_bubble", 32'(ex_valid), 32'h0);
    check("lu_hazard_drop", 32'(hazard), 32'h0);
    pc_in = 32'h208; instr_in = NOP; tick();
    check("lu_add_valid", 32'(ex_valid), 32'h1);
    check("lu_add_rs1", 32'(ex_rs1), 32'd2);
    check("lu_add_pc", ex_pc, 32'h204);

    // Load to x0 never stalls.
    pc_in = 32'h300; instr_in = 32'h0000A003; tick();
    pc_in = 32'h304; instr_in = 32'h001001B3; tick();
    check("x0_hazard", 32'(hazard), 32'h0);
    pc_in = 32'h308; instr_in = NOP; tick();
    check("x0_add_pc", ex_pc, 32'h304);

    // Flush while stalled.
    pc_in = 32'h400; instr_in = 32'h0000A103; tick();
    pc_in = 32'h404; instr_in = 32'h001101B3; tick();
    check("fl_pre_hazard", 32'(hazard), 32'h1);
    flush = 1'b1; #1;
    check("fl_hazard", 32'(hazard), 32'h0);
    tick();
    flush = 1'b0;
    check("fl_ex_valid", 32'(ex_valid), 32'h0);
    check("fl_id_valid", 32'(dut.id_valid_q), 32'h0);
    check("fl_id_instr", dut.id_instr_q, NOP);
    pc_in = 32'h500; instr_in = NOP; tick();
    check("fl_next_bubble", 32'(ex_valid), 32'h0);

    // Reset in the middle of a stall.
    pc_in = 32'h600; instr_in = 32'h0000A103; tick();
    pc_in = 32'h604; instr_in = 32'h001101B3; tick();
    check("rs_pre_hazard", 32'(hazard), 32'h1);
    reset_n = 1'b0; tick();
    check_bundle("rs_ex", dut_bundle(), zero_b);
    check("rs_hazard", 32'(hazard), 32'h0);
    check("rs_id_valid", 32'(dut.id_valid_q), 32'h0);
    reset_n = 1'b1;

    // Writeback in the same cycle as the decode of add x6,x5,x0.
    pc_in = 32'h700; instr_in = 32'h00028333; tick();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; instr_in = NOP; tick();
    wb_we = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    check("wb_rs1_data", ex_rs1_data, 32'hDEADBEEF);
`else
    check("wb_rs1_data", ex_rs1_data, m_regs[5]);
`endif
    check("wb_rs1_idx", 32'(ex_rs1), 32'd5);
    m_regs[5] = 32'hDEADBEEF;

    // Writes to x0 are dropped.
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; tick();
    wb_we = 1'b0;
    instr_in = 32'h00500333; tick();
    instr_in = NOP; tick();
    check("x0_read_zero", ex_rs1_data, 32'h0);
    check("x5_after_wb", ex_rs2_data, 32'hDEADBEEF);

    run_random(200, 32'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
